// File: rtl/matmul_int_pkg.sv
// Shared types and elaboration helpers for the sequential MX integer matmul.
package matmul_int_pkg;

  typedef enum logic [1:0] {IDLE, RUN, NORM, OUT} state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Full-precision sum of VEC products plus one guard bit.
  function automatic int unsigned acc_width(input int unsigned bit_w, input int unsigned vec);
    return 2 * bit_w + $clog2(vec) + 1;
  endfunction

  function automatic int sat_scale(input int value, input int unsigned width);
    int max_v;
    max_v = (1 << width) - 1;
    if (value < 0) return 0;
    if (value > max_v) return max_v;
    return value;
  endfunction

endpackage

// File: rtl/mx_block_dot_int.sv
// Combinational K-lane signed dot product for one MX block.
module mx_block_dot_int #(
  parameter int unsigned K         = 2,
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH = 20
) (
  input  logic        [K-1:0][BIT_WIDTH-1:0] a_i,
  input  logic        [K-1:0][BIT_WIDTH-1:0] b_i,
  output logic signed [ACC_WIDTH-1:0]        p_o
);

  logic signed [2*BIT_WIDTH-1:0] prod;

  always_comb begin
    p_o  = '0;
    prod = '0;
    for (int unsigned n = 0; n < K; n++) begin
      prod = $signed(a_i[n]) * $signed(b_i[n]);
      p_o  = p_o + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/matmul_int_seq.sv
// Time-multiplexed MX integer matmul: one K-element block per cycle, scale-aligned
// accumulation, per-element normalisation, row-major valid/ready output stream.
module matmul_int_seq
  import matmul_int_pkg::*;
#(
  parameter int unsigned X_ROWS         = 4,
  parameter int unsigned VEC_ELEM_COUNT = 8,
  parameter int unsigned Y_COLS         = 2,
  parameter int unsigned K              = 2,
  parameter int unsigned BIT_WIDTH      = 8,
  parameter int unsigned OUT_WIDTH      = 8,
  parameter int unsigned SCALE_WIDTH    = 8,
  parameter int          SCALE_BIAS     = 127,
  parameter int unsigned ACC_WIDTH      = acc_width(BIT_WIDTH, VEC_ELEM_COUNT),
  localparam int unsigned BLOCK_COUNT   = VEC_ELEM_COUNT / K,
  localparam int unsigned ROW_W         = clog2_min1(X_ROWS),
  localparam int unsigned COL_W         = clog2_min1(Y_COLS)
) (
  input  logic                                                   i_clk,
  input  logic                                                   i_rst_n,
  input  logic                                                   i_valid,
  output logic                                                   o_ready,
  input  logic [X_ROWS-1:0][VEC_ELEM_COUNT-1:0][BIT_WIDTH-1:0]   A_i,
  input  logic [VEC_ELEM_COUNT-1:0][Y_COLS-1:0][BIT_WIDTH-1:0]   B_i,
  input  logic [X_ROWS-1:0][BLOCK_COUNT-1:0][SCALE_WIDTH-1:0]    S_A_i,
  input  logic [BLOCK_COUNT-1:0][Y_COLS-1:0][SCALE_WIDTH-1:0]    S_B_i,
  output logic                                                   o_valid,
  input  logic                                                   i_ready,
  output logic [ROW_W-1:0]                                       o_row,
  output logic [COL_W-1:0]                                       o_col,
  output logic [OUT_WIDTH-1:0]                                   C_o,
  output logic [SCALE_WIDTH-1:0]                                 S_C_o,
  output logic                                                   o_last
);

  localparam int unsigned BLK_W = clog2_min1(BLOCK_COUNT);
  localparam logic [BLK_W-1:0]       B_LAST = BLK_W'(BLOCK_COUNT - 1);
  localparam logic [ROW_W-1:0]       I_LAST = ROW_W'(X_ROWS - 1);
  localparam logic [COL_W-1:0]       J_LAST = COL_W'(Y_COLS - 1);
  localparam logic [SCALE_WIDTH:0]   D_MAX  = (SCALE_WIDTH + 1)'(ACC_WIDTH - 1);

  state_t state_q, state_d;
  logic [ROW_W-1:0] i_q, i_d, row_q, row_d;
  logic [COL_W-1:0] j_q, j_d, col_q, col_d;
  logic [BLK_W-1:0] b_q, b_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [SCALE_WIDTH:0]        acc_e_q, acc_e_d;
  logic [OUT_WIDTH-1:0]        c_q, c_d;
  logic [SCALE_WIDTH-1:0]      s_c_q, s_c_d;
  logic                        last_q, last_d;

  logic [X_ROWS-1:0][VEC_ELEM_COUNT-1:0][BIT_WIDTH-1:0]  a_q, a_d;
  logic [VEC_ELEM_COUNT-1:0][Y_COLS-1:0][BIT_WIDTH-1:0]  b_op_q, b_op_d;
  logic [X_ROWS-1:0][BLOCK_COUNT-1:0][SCALE_WIDTH-1:0]   s_a_q, s_a_d;
  logic [BLOCK_COUNT-1:0][Y_COLS-1:0][SCALE_WIDTH-1:0]   s_b_q, s_b_d;

  logic [K-1:0][BIT_WIDTH-1:0] a_blk, b_blk;
  logic signed [ACC_WIDTH-1:0] p;
  logic [SCALE_WIDTH:0]        e, diff, d;
  logic signed [ACC_WIDTH-1:0] sh;
  logic [OUT_WIDTH-1:0]        c_norm;
  int unsigned                 s_sel;
  logic                        found;

  // Block operand and scale selection for the current (i, j, b)
  always_comb begin
    a_blk = '0;
    b_blk = '0;
    for (int unsigned n = 0; n < K; n++) begin
      a_blk[n] = a_q[i_q][int'(b_q) * K + n];
      b_blk[n] = b_op_q[int'(b_q) * K + n][j_q];
    end
    e    = (SCALE_WIDTH + 1)'(s_a_q[i_q][b_q]) + (SCALE_WIDTH + 1)'(s_b_q[b_q][j_q]);
    diff = (e > acc_e_q) ? (e - acc_e_q) : (acc_e_q - e);
    d    = (diff > D_MAX) ? D_MAX : diff;
  end

  mx_block_dot_int #(
    .K         (K),
    .BIT_WIDTH (BIT_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_dot (
    .a_i (a_blk),
    .b_i (b_blk),
    .p_o (p)
  );

  // Smallest shift whose result has only sign bits above OUT_WIDTH-1
  always_comb begin
    found  = 1'b0;
    s_sel  = 0;
    c_norm = '0;
    sh     = '0;
    for (int unsigned s = 0; s < ACC_WIDTH; s++) begin
      sh = acc_q >>> s;
      if (!found && ((&sh[ACC_WIDTH-1:OUT_WIDTH-1]) || !(|sh[ACC_WIDTH-1:OUT_WIDTH-1]))) begin
        found  = 1'b1;
        s_sel  = s;
        c_norm = sh[OUT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    b_d     = b_q;
    acc_d   = acc_q;
    acc_e_d = acc_e_q;
    row_d   = row_q;
    col_d   = col_q;
    c_d     = c_q;
    s_c_d   = s_c_q;
    last_d  = last_q;
    a_d     = a_q;
    b_op_d  = b_op_q;
    s_a_d   = s_a_q;
    s_b_d   = s_b_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = A_i;
          b_op_d  = B_i;
          s_a_d   = S_A_i;
          s_b_d   = S_B_i;
          i_d     = '0;
          j_d     = '0;
          b_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (b_q == '0) begin
          acc_d   = p;
          acc_e_d = e;
        end else if (p != '0) begin
          if (e > acc_e_q) begin
            acc_d   = (acc_q >>> d) + p;
            acc_e_d = e;
          end else begin
            acc_d = acc_q + (p >>> d);
          end
        end
        if (b_q == B_LAST) state_d = NORM;
        else               b_d     = b_q + 1'b1;
      end
      NORM: begin
        c_d     = c_norm;
        s_c_d   = SCALE_WIDTH'(sat_scale(int'(acc_e_q) + int'(s_sel) - SCALE_BIAS, SCALE_WIDTH));
        row_d   = i_q;
        col_d   = j_q;
        last_d  = (i_q == I_LAST) && (j_q == J_LAST);
        state_d = OUT;
      end
      OUT: begin
        if (i_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            b_d = '0;
            if (j_q == J_LAST) begin
              j_d = '0;
              i_d = i_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      acc_e_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      c_q     <= '0;
      s_c_q   <= '0;
      last_q  <= 1'b0;
      a_q     <= '0;
      b_op_q  <= '0;
      s_a_q   <= '0;
      s_b_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      acc_e_q <= acc_e_d;
      row_q   <= row_d;
      col_q   <= col_d;
      c_q     <= c_d;
      s_c_q   <= s_c_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_op_q  <= b_op_d;
      s_a_q   <= s_a_d;
      s_b_q   <= s_b_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == OUT);
  assign o_row   = row_q;
  assign o_col   = col_q;
  assign C_o     = c_q;
  assign S_C_o   = s_c_q;
  assign o_last  = last_q;

endmodule
